bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for a single-cycle RAM bus, with a burst
// limit that forces handover when the other master is waiting.
module bus_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wData,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rData,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wData,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rData,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  output logic [3:0]  busWstrb,
  input  logic [31:0] busRData,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arbState_e;

  arbState_e  state;
  arbState_e  nextState;
  logic       lastOwn;
  logic [3:0] burstCnt;
  logic       xfer0;
  logic       xfer1;
  logic       burstDone;

  assign xfer0     = (state == OWN0) && m0_req;
  assign xfer1     = (state == OWN1) && m1_req;
  assign burstDone = ({1'b0, burstCnt} + 5'd1) >= 5'(BURST_MAX);

  // lastOwn = 1 means m1 owned last, so reset leaves m0 winning the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lastOwn  <= 1'b1;
      burstCnt <= 4'd0;
    end else begin
      state <= nextState;
      if (state == OWN0) begin
        lastOwn <= 1'b0;
      end else if (state == OWN1) begin
        lastOwn <= 1'b1;
      end
      if ((nextState == OWN0 || nextState == OWN1) && nextState != state) begin
        burstCnt <= 4'd0;
      end else if ((xfer0 || xfer1) && burstCnt != 4'hF) begin
        burstCnt <= burstCnt + 4'd1;
      end
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          nextState = lastOwn ? OWN0 : OWN1;
        end else if (m0_req) begin
          nextState = OWN0;
        end else if (m1_req) begin
          nextState = OWN1;
        end else begin
          nextState = IDLE;
        end
      end
      OWN0: begin
        if (!m0_req) begin
          nextState = m1_req ? OWN1 : IDLE;
        end else if (m1_req && burstDone) begin
          nextState = OWN1;
        end else begin
          nextState = OWN0;
        end
      end
      OWN1: begin
        if (!m1_req) begin
          nextState = m0_req ? OWN0 : IDLE;
        end else if (m0_req && burstDone) begin
          nextState = OWN0;
        end else begin
          nextState = OWN1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Bus fields stay zero unless the owner is actually transferring this cycle.
  always_comb begin
    gnt      = 2'b00;
    busWe    = 1'b0;
    busAddr  = 32'd0;
    busWData = 32'd0;
    busWstrb = 4'd0;
    m0_ready = 1'b0;
    m0_rData = 32'd0;
    m1_ready = 1'b0;
    m1_rData = 32'd0;
    unique case (state)
      OWN0: begin
        gnt = 2'b01;
        if (xfer0) begin
          busWe    = m0_we;
          busAddr  = m0_addr;
          busWData = m0_wData;
          busWstrb = m0_wstrb;
          m0_ready = 1'b1;
          m0_rData = busRData;
        end
      end
      OWN1: begin
        gnt = 2'b10;
        if (xfer1) begin
          busWe    = m1_we;
          busAddr  = m1_addr;
          busWData = m1_wData;
          busWstrb = m1_wstrb;
          m1_ready = 1'b1;
          m1_rData = busRData;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule
